// File: rtl/ps2_led_command_sequencer.sv
// Tracks the Caps/Num/Scroll lock state and pushes it to the keyboard with the
// two-byte "Set LEDs" command (0xED, LED byte), handling ACK, Resend, timeout and 0xAA re-sync.
module ps2_led_command_sequencer #(
    parameter int ACK_TIMEOUT = 1000000,
    parameter int TO_W        = 20,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       keycode_ready,
    input  logic [7:0] keycode,
    input  logic       ext,
    input  logic       make,
    input  logic [7:0] ps2_rx_data,
    input  logic       ps2_rx_en,
    input  logic       ps2_cmd_sent,
    input  logic       ps2_cmd_error,
    output logic       ps2_send_cmd,
    output logic [7:0] ps2_cmd_byte,
    output logic [2:0] led_state,
    output logic       busy,
    output logic       error
);

    localparam logic [2:0] S_IDLE          = 3'd0;
    localparam logic [2:0] S_SEND_ED       = 3'd1;
    localparam logic [2:0] S_WAIT_ED_SENT  = 3'd2;
    localparam logic [2:0] S_WAIT_ED_ACK   = 3'd3;
    localparam logic [2:0] S_SEND_LED      = 3'd4;
    localparam logic [2:0] S_WAIT_LED_SENT = 3'd5;
    localparam logic [2:0] S_WAIT_LED_ACK  = 3'd6;

    localparam logic [7:0] CODE_CAPS   = 8'h58;
    localparam logic [7:0] CODE_NUM    = 8'h77;
    localparam logic [7:0] CODE_SCROLL = 8'h7E;
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] RX_ACK      = 8'hFA;
    localparam logic [7:0] RX_RESEND   = 8'hFE;
    localparam logic [7:0] RX_BAT_OK   = 8'hAA;

    localparam int                 RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(ACK_TIMEOUT - 1);

    logic [2:0]         state_q,   state_d;
    logic [2:0]         led_q,     led_d;
    logic [2:0]         held_q,    held_d;
    logic               pending_q, pending_d;
    logic [RETRY_W-1:0] retry_q,   retry_d;
    logic [TO_W-1:0]    cnt_q,     cnt_d;
    logic [7:0]         byte_q,    byte_d;
    logic               send_q,    send_d;
    logic               error_q,   error_d;

    logic [2:0] key_sel;
    logic       toggle_req;
    logic       bat_req;
    logic       launch;
    logic       retry_evt;
    logic       fail;
    logic       in_led_byte;

    // One-hot {caps, num, scroll} select for a non-extended lock key event.
    always_comb begin
        key_sel = 3'b000;
        if (keycode_ready && !ext) begin
            case (keycode)
                CODE_CAPS:   key_sel = 3'b100;
                CODE_NUM:    key_sel = 3'b010;
                CODE_SCROLL: key_sel = 3'b001;
                default:     key_sel = 3'b000;
            endcase
        end
    end

    always_comb begin
        led_d      = led_q;
        held_d     = held_q;
        toggle_req = 1'b0;
        if (key_sel != 3'b000) begin
            if (make) begin
                // Typematic repeats arrive as further makes while held; only the first toggles.
                if ((held_q & key_sel) == 3'b000) begin
                    led_d      = led_q ^ key_sel;
                    toggle_req = 1'b1;
                end
                held_d = held_q | key_sel;
            end else begin
                held_d = held_q & ~key_sel;
            end
        end
    end

    assign in_led_byte = (state_q == S_WAIT_LED_SENT) || (state_q == S_WAIT_LED_ACK);

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        error_d   = error_q;
        launch    = 1'b0;
        bat_req   = 1'b0;
        retry_evt = 1'b0;
        fail      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ps2_rx_en && ps2_rx_data == RX_BAT_OK) begin
                    bat_req = 1'b1;
                end
                if (pending_q) begin
                    launch  = 1'b1;
                    error_d = 1'b0;
                    retry_d = '0;
                    byte_d  = CMD_SET_LED;
                    state_d = S_SEND_ED;
                end
            end
            S_SEND_ED:  state_d = S_WAIT_ED_SENT;
            S_SEND_LED: state_d = S_WAIT_LED_SENT;
            S_WAIT_ED_SENT, S_WAIT_LED_SENT: begin
                if (ps2_cmd_sent) begin
                    cnt_d   = '0;
                    state_d = in_led_byte ? S_WAIT_LED_ACK : S_WAIT_ED_ACK;
                end else if (ps2_cmd_error) begin
                    retry_evt = 1'b1;
                end
            end
            S_WAIT_ED_ACK, S_WAIT_LED_ACK: begin
                cnt_d = cnt_q + 1'b1;
                // A response byte landing on the expiry cycle wins over the timeout.
                if (ps2_rx_en && ps2_rx_data == RX_ACK) begin
                    if (in_led_byte) begin
                        state_d = S_IDLE;
                    end else begin
                        retry_d = '0;
                        byte_d  = {5'b00000, led_q};
                        state_d = S_SEND_LED;
                    end
                end else if (ps2_rx_en && ps2_rx_data == RX_RESEND) begin
                    retry_evt = 1'b1;
                end else if (cnt_q == TO_LAST) begin
                    fail = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (retry_evt) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 1'b1;
                state_d = in_led_byte ? S_SEND_LED : S_SEND_ED;
            end else begin
                fail = 1'b1;
            end
        end

        // Failure keeps led_state and any pending request so a later event retries.
        if (fail) begin
            error_d = 1'b1;
            state_d = S_IDLE;
        end
    end

    assign pending_d = toggle_req | bat_req | (pending_q & ~launch);
    assign send_d    = (state_d == S_SEND_ED) || (state_d == S_SEND_LED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            led_q     <= 3'b000;
            held_q    <= 3'b000;
            pending_q <= 1'b0;
            retry_q   <= '0;
            cnt_q     <= '0;
            byte_q    <= 8'h00;
            send_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            led_q     <= led_d;
            held_q    <= held_d;
            pending_q <= pending_d;
            retry_q   <= retry_d;
            cnt_q     <= cnt_d;
            byte_q    <= byte_d;
            send_q    <= send_d;
            error_q   <= error_d;
        end
    end

    assign ps2_send_cmd = send_q;
    assign ps2_cmd_byte = byte_q;
    assign led_state    = led_q;
    assign busy         = (state_q != S_IDLE);
    assign error        = error_q;

endmodule

// File: tb/tb_ps2_led_command_sequencer.sv
// Bench for ps2_led_command_sequencer: a keyboard/controller responder drives the DUT,
// and a behavioural model of the LED command protocol is compared against it every cycle.
module tb_ps2_led_command_sequencer;

    localparam int ACK_TIMEOUT = 100;
    localparam int TO_W        = 8;
    localparam int MAX_RETRY   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       keycode_ready = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       ext = 1'b0;
    logic       make = 1'b0;
    logic [7:0] ps2_rx_data = 8'h00;
    logic       ps2_rx_en = 1'b0;
    logic       ps2_cmd_sent = 1'b0;
    logic       ps2_cmd_error = 1'b0;
    logic       ps2_send_cmd;
    logic [7:0] ps2_cmd_byte;
    logic [2:0] led_state;
    logic       busy;
    logic       error;

    ps2_led_command_sequencer #(
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .TO_W       (TO_W),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .keycode_ready(keycode_ready),
        .keycode      (keycode),
        .ext          (ext),
        .make         (make),
        .ps2_rx_data  (ps2_rx_data),
        .ps2_rx_en    (ps2_rx_en),
        .ps2_cmd_sent (ps2_cmd_sent),
        .ps2_cmd_error(ps2_cmd_error),
        .ps2_send_cmd (ps2_send_cmd),
        .ps2_cmd_byte (ps2_cmd_byte),
        .led_state    (led_state),
        .busy         (busy),
        .error        (error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Protocol model: where the host is in the command exchange, which byte, attempts used.
    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_TX   = 2;
    localparam int P_RSP  = 3;

    logic [2:0] m_led = 3'b000;
    logic [2:0] m_held = 3'b000;
    logic [2:0] m_led_before;
    logic [7:0] m_byte = 8'h00;
    bit         m_pend = 1'b0;
    bit         m_err = 1'b0;
    bit         m_valid = 1'b0;
    bit         m_new_req, m_retry_ev, m_fail;
    int         m_phase = P_IDLE;
    int         m_second = 0;
    int         m_att = 0;
    int         m_waited = 0;
    int         m_bit;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_led = 3'b000; m_held = 3'b000; m_byte = 8'h00; m_pend = 1'b0; m_err = 1'b0;
            m_phase = P_IDLE; m_second = 0; m_att = 0; m_waited = 0; m_valid = 1'b1;
        end else begin
            m_led_before = m_led;
            m_new_req = 1'b0; m_retry_ev = 1'b0; m_fail = 1'b0;
            m_bit = -1;
            if (keycode_ready && !ext) begin
                if (keycode == 8'h58) m_bit = 2;
                else if (keycode == 8'h77) m_bit = 1;
                else if (keycode == 8'h7E) m_bit = 0;
            end
            if (m_bit >= 0) begin
                if (make) begin
                    if (!m_held[m_bit]) begin
                        m_led[m_bit] = ~m_led[m_bit];
                        m_new_req = 1'b1;
                    end
                    m_held[m_bit] = 1'b1;
                end else begin
                    m_held[m_bit] = 1'b0;
                end
            end
            if (m_phase == P_IDLE && ps2_rx_en && ps2_rx_data == 8'hAA) m_new_req = 1'b1;

            if (m_phase == P_IDLE) begin
                if (m_pend) begin
                    m_pend = 1'b0; m_err = 1'b0; m_second = 0; m_att = 1;
                    m_byte = 8'hED; m_phase = P_REQ;
                end
            end else if (m_phase == P_REQ) begin
                m_phase = P_TX;
            end else if (m_phase == P_TX) begin
                if (ps2_cmd_sent) begin
                    m_waited = 0; m_phase = P_RSP;
                end else if (ps2_cmd_error) begin
                    m_retry_ev = 1'b1;
                end
            end else begin
                m_waited++;
                if (ps2_rx_en && ps2_rx_data == 8'hFA) begin
                    if (m_second != 0) begin
                        m_phase = P_IDLE;
                    end else begin
                        m_second = 1; m_att = 1;
                        m_byte = {5'b00000, m_led_before}; m_phase = P_REQ;
                    end
                end else if (ps2_rx_en && ps2_rx_data == 8'hFE) begin
                    m_retry_ev = 1'b1;
                end else if (m_waited >= ACK_TIMEOUT) begin
                    m_fail = 1'b1;
                end
            end
            if (m_retry_ev) begin
                if (m_att <= MAX_RETRY) begin
                    m_att++; m_phase = P_REQ;
                end else begin
                    m_fail = 1'b1;
                end
            end
            if (m_fail) begin
                m_err = 1'b1; m_phase = P_IDLE;
            end
            m_pend = m_pend | m_new_req;
        end
    end

    // Responder acting as PS2 controller + keyboard.
    localparam int A_ACK    = 0;
    localparam int A_RESEND = 1;
    localparam int A_TXERR  = 2;
    localparam int A_SILENT = 3;
    localparam int A_NOISE  = 4;

    int         act_q[$];
    logic [7:0] sent_q[$];
    bit         rand_mode = 1'b0;
    int         rs = 0;
    int         rdel = 0;
    int         ract = 0;
    int         sent_cyc = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int next_action();
        int r;
        if (act_q.size() > 0) return act_q.pop_front();
        if (!rand_mode) return A_ACK;
        r = $urandom_range(0, 99);
        if (r < 70) return A_ACK;
        if (r < 80) return A_RESEND;
        if (r < 88) return A_TXERR;
        if (r < 98) return A_NOISE;
        return A_SILENT;
    endfunction

    task automatic respond();
        logic [7:0] nb;
        if (reset) begin
            rs = 0;
            return;
        end
        case (rs)
            0: if (ps2_send_cmd === 1'b1) begin
                ract = next_action(); rdel = $urandom_range(1, 3); rs = 1;
            end
            1: if (rdel > 1) begin
                rdel--;
            end else if (ract == A_TXERR) begin
                ps2_cmd_error = 1'b1; rs = 0;
            end else begin
                ps2_cmd_sent = 1'b1; sent_cyc = cyc;
                rdel = $urandom_range(1, 6);
                rs = (ract == A_SILENT) ? 0 : 2;
            end
            default: if (rdel > 1) begin
                rdel--;
            end else begin
                ps2_rx_en = 1'b1;
                if (ract == A_NOISE) begin
                    nb = 8'($urandom_range(0, 255));
                    if (nb == 8'hFA || nb == 8'hFE) nb = 8'h00;
                    ps2_rx_data = nb; ract = A_ACK; rdel = $urandom_range(1, 4);
                end else begin
                    ps2_rx_data = (ract == A_RESEND) ? 8'hFE : 8'hFA; rs = 0;
                end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        if (m_valid) begin
            chk("led_state", {29'd0, led_state}, {29'd0, m_led});
            chk("ps2_send_cmd", {31'd0, ps2_send_cmd}, {31'd0, m_phase == P_REQ});
            chk("ps2_cmd_byte", {24'd0, ps2_cmd_byte}, {24'd0, m_byte});
            chk("busy", {31'd0, busy}, {31'd0, m_phase != P_IDLE});
            chk("error", {31'd0, error}, {31'd0, m_err});
        end
        if (ps2_send_cmd === 1'b1) sent_q.push_back(ps2_cmd_byte);
        keycode_ready = 1'b0; ps2_rx_en = 1'b0; ps2_cmd_sent = 1'b0; ps2_cmd_error = 1'b0;
        respond();
    endtask

    task automatic key(logic [7:0] c, logic e, logic mk);
        keycode_ready = 1'b1; keycode = c; ext = e; make = mk;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        sent_q.delete();
        act_q.delete();
    endtask

    task automatic wait_quiet(string name);
        int q = 0;
        int n = 0;
        while (q < 4 && n < 3000) begin
            tick();
            n++;
            if (busy === 1'b0) q++;
            else q = 0;
        end
        chk({name, "_settle"}, {31'd0, q >= 4}, 32'd1);
    endtask

    task automatic check_seq(string name, int n, logic [31:0] exp);
        chk({name, "_count"}, sent_q.size(), n);
        for (int i = 0; i < n && i < sent_q.size(); i++)
            chk({name, "_byte"}, {24'd0, sent_q[i]}, {24'd0, exp[8*(n-1-i) +: 8]});
    endtask

    initial begin
        int n;
        do_reset();
        chk("reset_led", {29'd0, led_state}, 32'd0);
        chk("reset_send", {31'd0, ps2_send_cmd}, 32'd0);
        chk("reset_byte", {24'd0, ps2_cmd_byte}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_error", {31'd0, error}, 32'd0);

        // Caps make: LED update next cycle, 0xED request one cycle later.
        key(8'h58, 1'b0, 1'b1);
        tick();
        chk("t1_led", {29'd0, led_state}, 32'h4);
        chk("t1_send_early", {31'd0, ps2_send_cmd}, 32'd0);
        tick();
        chk("t1_send", {31'd0, ps2_send_cmd}, 32'd1);
        chk("t1_byte", {24'd0, ps2_cmd_byte}, 32'hED);
        wait_quiet("t1");
        check_seq("t1_seq", 2, 32'h0000ED04);
        chk("t1_error", {31'd0, error}, 32'd0);

        // Num make, repeat, break, make.
        do_reset();
        key(8'h77, 1'b0, 1'b1);
        tick();
        key(8'h77, 1'b0, 1'b1);
        tick();
        chk("t2_led_a", {29'd0, led_state}, 32'h2);
        wait_quiet("t2a");
        key(8'h77, 1'b0, 1'b0);
        tick();
        key(8'h77, 1'b0, 1'b1);
        wait_quiet("t2b");
        chk("t2_led_b", {29'd0, led_state}, 32'h0);
        check_seq("t2_seq", 4, 32'hED02ED00);

        // Two resends of 0xED before ACK.
        do_reset();
        act_q = '{A_RESEND, A_RESEND, A_ACK, A_ACK};
        key(8'h7E, 1'b0, 1'b1);
        wait_quiet("t3");
        check_seq("t3_seq", 4, 32'hEDEDED01);
        chk("t3_error", {31'd0, error}, 32'd0);

        // No response after 0xED is sent.
        do_reset();
        act_q = '{A_SILENT};
        key(8'h58, 1'b0, 1'b1);
        n = 0;
        while (error !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("t4_timeout_seen", {31'd0, error === 1'b1}, 32'd1);
        chk("t4_latency", cyc - sent_cyc, 32'd101);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_led", {29'd0, led_state}, 32'h4);
        tick();
        tick();

        // Four transmit errors exhaust the retries.
        do_reset();
        act_q = '{A_TXERR, A_TXERR, A_TXERR, A_TXERR};
        key(8'h58, 1'b0, 1'b1);
        wait_quiet("t5");
        check_seq("t5_seq", 4, 32'hEDEDEDED);
        chk("t5_error", {31'd0, error}, 32'd1);
        // Keyboard self-test in IDLE re-sends the current state and clears error.
        sent_q.delete();
        act_q = '{A_ACK, A_ACK};
        ps2_rx_en = 1'b1; ps2_rx_data = 8'hAA;
        wait_quiet("t5_bat");
        check_seq("t5_bat_seq", 2, 32'h0000ED04);
        chk("t5_bat_error", {31'd0, error}, 32'd0);

        // Scroll toggled after the LED byte of a running sequence went out.
        do_reset();
        key(8'h58, 1'b0, 1'b1);
        n = 0;
        while (sent_q.size() < 2 && n < 200) begin
            tick();
            n++;
        end
        chk("t6_first_pair", {31'd0, sent_q.size() >= 2}, 32'd1);
        chk("t6_busy_mid", {31'd0, busy}, 32'd1);
        key(8'h7E, 1'b0, 1'b1);
        wait_quiet("t6");
        chk("t6_led", {29'd0, led_state}, 32'h5);
        check_seq("t6_seq", 4, 32'hED04ED05);

        // Reset in the middle of a sequence.
        do_reset();
        key(8'h77, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        chk("t7_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        sent_q.delete();
        tick();
        chk("t7_led", {29'd0, led_state}, 32'd0);
        chk("t7_busy", {31'd0, busy}, 32'd0);
        chk("t7_send", {31'd0, ps2_send_cmd}, 32'd0);
        chk("t7_byte", {24'd0, ps2_cmd_byte}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("t7_no_strobe", sent_q.size(), 32'd0);

        // Randomized traffic against the model.
        rand_mode = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 3))
                    0: keycode = 8'h58;
                    1: keycode = 8'h77;
                    2: keycode = 8'h7E;
                    default: keycode = 8'h1C;
                endcase
                keycode_ready = 1'b1;
                ext = ($urandom_range(0, 9) == 0);
                make = ($urandom_range(0, 9) < 6);
            end
            if (!ps2_rx_en && $urandom_range(0, 149) == 0) begin
                ps2_rx_en = 1'b1; ps2_rx_data = 8'hAA;
            end
            if ($urandom_range(0, 1499) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
        end
        wait_quiet("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
